// File: rtl/video_mem_responder.sv
// video_mem_responder: Wishbone B4 pipelined responder for the VRAM/VROM region of the external SRAM.
//   Accepts requests back-to-back, issues them to the SRAM in order and terminates each one
//   READ_LATENCY+1 edges after acceptance (ack for reads and writes alike).
//   Ports: wb_clock_i/reset_ni (async active-low); wb_addr_i/wb_data_i/wb_we_i/wb_cycle_i/wb_strobe_i in;
//   wb_data_o/wb_stall_o/wb_ack_o out; ram_addr_o/ram_data_o/ram_we_o/ram_oe_o to the SRAM, ram_data_i from it.
//   Optional macro VIDEO_MEM_RESPONDER_ERR_EN adds wb_err_o: requests with address bits above
//   RAM_ADDR_WIDTH-1 set are accepted, never reach the SRAM, and terminate with wb_err_o.
module video_mem_responder #(
  parameter int RAM_ADDR_WIDTH  = 17,
  parameter int WB_ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH      = 8,
  parameter int READ_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      wb_clock_i,
  input  logic                      reset_ni,
  input  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i,
  input  logic [DATA_WIDTH-1:0]     wb_data_i,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  input  logic                      wb_we_i,
  input  logic                      wb_cycle_i,
  input  logic                      wb_strobe_i,
  output logic                      wb_stall_o,
  output logic                      wb_ack_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0]     ram_data_i,
  output logic [DATA_WIDTH-1:0]     ram_data_o,
  output logic                      ram_we_o,
  output logic                      ram_oe_o
`ifdef VIDEO_MEM_RESPONDER_ERR_EN
  , output logic                    wb_err_o
`endif
);
  localparam int L  = READ_LATENCY + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [L-1:0]  vld, wr, bad;
  logic [CW-1:0] count;
  logic          err_q, accept, issue, term, oob;
`ifdef VIDEO_MEM_RESPONDER_ERR_EN
  assign oob      = |(wb_addr_i >> RAM_ADDR_WIDTH);
  assign wb_err_o = err_q;
`else
  logic unused_hi;
  assign oob       = 1'b0;
  assign unused_hi = ^(wb_addr_i >> RAM_ADDR_WIDTH);
`endif
  // a termination this cycle frees a slot, so a full responder can still accept
  assign term       = wb_ack_o | err_q;
  assign wb_stall_o = (count == CW'(MAX_OUTSTANDING)) & ~term;
  assign accept     = wb_cycle_i & wb_strobe_i & ~wb_stall_o;
  assign issue      = accept & ~oob;
  // stage L-1 holds a read until its data is captured, so it still needs the SRAM driving
  assign ram_oe_o   = |(vld & ~wr & ~bad) & ~ram_we_o;
  always_ff @(posedge wb_clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vld        <= '0;
      wr         <= '0;
      bad        <= '0;
      count      <= '0;
      wb_ack_o   <= 1'b0;
      err_q      <= 1'b0;
      wb_data_o  <= '0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      ram_we_o   <= 1'b0;
    end else begin
      // dropping wb_cycle_i abandons everything in flight; issued writes stay written
      vld       <= wb_cycle_i ? {vld[L-2:0], accept} : '0;
      wr        <= {wr[L-2:0], wb_we_i};
      bad       <= {bad[L-2:0], oob};
      wb_ack_o  <= wb_cycle_i & vld[L-1] & ~bad[L-1];
      err_q     <= wb_cycle_i & vld[L-1] & bad[L-1];
      wb_data_o <= (vld[L-1] & ~wr[L-1] & ~bad[L-1]) ? ram_data_i : '0;
      count     <= wb_cycle_i ? count + CW'(accept) - CW'(term) : '0;
      ram_we_o  <= issue & wb_we_i;
      if (issue) begin
        ram_addr_o <= wb_addr_i[RAM_ADDR_WIDTH-1:0];
        ram_data_o <= wb_data_i;
      end
    end
  end
endmodule

// File: tb/tb_video_mem_responder.sv
// tb_video_mem_responder: scoreboard bench for video_mem_responder (two instances, MAX_OUTSTANDING 4 and 2).
module tb_video_mem_responder;
  typedef struct { logic [7:0] d; logic e; int c; } exp_t;
  logic        clk, rst_n;
  logic        cyc [2], stb [2], we [2], ack [2], stall [2], rwe [2], oe [2];
  logic [23:0] addr [2];
  logic [7:0]  wdat [2], rdat_o [2], rdi [2], rdo [2];
  logic [16:0] raddr [2], a1 [2];
  logic [1:0]  err;
  logic [7:0]  mem [0:511];
  exp_t        sb [2][$];
  int          cyc_n = 0, total = 0, passed = 0, we_cnt = 0, oe_cnt = 0;
  int          nresp [2] = '{0, 0};

  video_mem_responder #(.MAX_OUTSTANDING(4)) u_a (
    .wb_clock_i(clk), .reset_ni(rst_n), .wb_addr_i(addr[0]), .wb_data_i(wdat[0]), .wb_data_o(rdat_o[0]),
    .wb_we_i(we[0]), .wb_cycle_i(cyc[0]), .wb_strobe_i(stb[0]), .wb_stall_o(stall[0]), .wb_ack_o(ack[0]),
    .ram_addr_o(raddr[0]), .ram_data_i(rdi[0]), .ram_data_o(rdo[0]), .ram_we_o(rwe[0]), .ram_oe_o(oe[0])
`ifdef VIDEO_MEM_RESPONDER_ERR_EN
    , .wb_err_o(err[0])
`endif
  );
  video_mem_responder #(.MAX_OUTSTANDING(2)) u_b (
    .wb_clock_i(clk), .reset_ni(rst_n), .wb_addr_i(addr[1]), .wb_data_i(wdat[1]), .wb_data_o(rdat_o[1]),
    .wb_we_i(we[1]), .wb_cycle_i(cyc[1]), .wb_strobe_i(stb[1]), .wb_stall_o(stall[1]), .wb_ack_o(ack[1]),
    .ram_addr_o(raddr[1]), .ram_data_i(rdi[1]), .ram_data_o(rdo[1]), .ram_we_o(rwe[1]), .ram_oe_o(oe[1])
`ifdef VIDEO_MEM_RESPONDER_ERR_EN
    , .wb_err_o(err[1])
`endif
  );
`ifndef VIDEO_MEM_RESPONDER_ERR_EN
  assign err = 2'b00;
`endif

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      'h123:   return 8'hA5;
      'h10:    return 8'h01;
      'h11:    return 8'h02;
      'h12:    return 8'h03;
      'h13:    return 8'h04;
      default: return 8'(i + 'h80);
    endcase
  endfunction

  // SRAM model: data for an address issued at edge N is presented after edge N+2
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
    else for (int k = 0; k < 2; k++) if (rwe[k]) mem[raddr[k][8:0]] <= rdo[k];
    for (int k = 0; k < 2; k++) begin
      a1[k]  <= raddr[k];
      rdi[k] <= mem[a1[k][8:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (rwe[0]) we_cnt++;
    if (oe[0]) oe_cnt++;
    check("we_oe_excl", {31'b0, rwe[0] & oe[0]}, 0);
    for (int k = 0; k < 2; k++) if (ack[k] || err[k]) begin
      nresp[k]++;
      if (sb[k].size() == 0) check("resp_expected", {30'b0, ack[k], err[k]}, 0);
      else begin
        exp_t x;
        x = sb[k].pop_front();
        check("resp_data", {24'b0, rdat_o[k]}, {24'b0, x.d});
        check("resp_kind", {30'b0, ack[k], err[k]}, {30'b0, ~x.e, x.e});
        check("resp_latency", cyc_n, x.c);
      end
    end
  end

  task automatic send(input int k, input logic w, input logic [23:0] a, input logic [7:0] d,
                      input logic push, input logic [7:0] xd, input logic xe, output int acc, output int waits);
    exp_t x;
    @(negedge clk);
    cyc[k] = 1; stb[k] = 1; we[k] = w; addr[k] = a; wdat[k] = d; waits = 0;
    while (stall[k] && waits < 50) begin @(negedge clk); waits++; end
    if (stall[k]) check("accept_timeout", {31'b0, stall[k]}, 0);
    acc = cyc_n + 1;
    x.d = xd; x.e = xe; x.c = acc + 3;
    if (push) sb[k].push_back(x);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    stb[k] = 0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (sb[k].size() != 0 && n < 60) begin @(negedge clk); n++; end
    check("drain_timeout", sb[k].size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int e1, e2, e3, w1, w2, w3, w4, n0, c0;
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; addr[k] = 0; wdat[k] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", {ack[0], stall[0], rwe[0], oe[0], rdat_o[0], raddr[0][4:0]}, 0);
    check("reset_ram_bus", {7'b0, raddr[0], rdo[0]}, 0);
    @(negedge clk) rst_n = 1;
    // single read
    send(0, 0, 24'h000123, 0, 1, 8'hA5, 0, e1, w1); idle(0); drain(0);
    // back-to-back reads never stall
    send(0, 0, 24'h000010, 0, 1, 8'h01, 0, e1, w1);
    send(0, 0, 24'h000011, 0, 1, 8'h02, 0, e2, w2);
    send(0, 0, 24'h000012, 0, 1, 8'h03, 0, e3, w3);
    send(0, 0, 24'h000013, 0, 1, 8'h04, 0, e3, w4);
    idle(0);
    check("b2b_no_stall", w1 + w2 + w3 + w4, 0);
    drain(0);
    // MAX_OUTSTANDING=2 under continuous strobe
    n0 = nresp[1];
    send(1, 0, 24'h000010, 0, 1, 8'h01, 0, e1, w1);
    send(1, 0, 24'h000011, 0, 1, 8'h02, 0, e2, w2);
    send(1, 0, 24'h000012, 0, 1, 8'h03, 0, e3, w3);
    idle(1);
    check("full_first_waits", w1 + w2, 0);
    check("full_stall_cycles", w3, 2);
    check("full_third_accept", e3 - e1, 4);
    drain(1);
    check("full_ack_count", nresp[1] - n0, 3);
    // write then read of the same address
    c0 = we_cnt;
    send(0, 1, 24'h000040, 8'h5A, 1, 8'h00, 0, e1, w1);
    send(0, 0, 24'h000040, 0, 1, 8'h5A, 0, e2, w2);
    idle(0); drain(0);
    check("we_pulse_cycles", we_cnt - c0, 1);
    // cycle abort
    n0 = nresp[0];
    send(0, 0, 24'h000010, 0, 0, 0, 0, e1, w1);
    send(0, 0, 24'h000011, 0, 0, 0, 0, e2, w2);
    @(negedge clk); cyc[0] = 0; stb[0] = 0;
    repeat (2) @(negedge clk);
    check("abort_count_clear", {29'b0, u_a.count}, 0);
    send(0, 0, 24'h000013, 0, 1, 8'h04, 0, e1, w1); idle(0); drain(0);
    check("abort_ack_count", nresp[0] - n0, 1);
`ifdef VIDEO_MEM_RESPONDER_ERR_EN
    c0 = oe_cnt;
    send(0, 0, 24'h020000, 0, 1, 8'h00, 1, e1, w1); idle(0); drain(0);
    check("err_no_oe", oe_cnt - c0, 0);
    send(0, 0, 24'h000123, 0, 1, 8'hA5, 0, e1, w1); idle(0); drain(0);
`endif
    // reset asserted mid-burst
    n0 = nresp[0];
    send(0, 0, 24'h000010, 0, 0, 0, 0, e1, w1);
    send(0, 0, 24'h000011, 0, 0, 0, 0, e2, w2);
    idle(0);
    #2 rst_n = 0;
    #1;
    check("rst_oe_clear", {31'b0, oe[0]}, 0);
    check("rst_count_clear", {29'b0, u_a.count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    check("rst_no_ack", nresp[0] - n0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
